// File: rtl/cpu_memory_arbiter.sv
// Shares the single memory port between instruction fetch and the MEM stage.
// Each grant runs ACCESS then RESP; ties are broken round-robin.
module cpu_memory_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_output_data,
  output logic        mmu_we,
  input  logic [31:0] mmu_input_data,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic [31:0] mem_hold_q, mem_hold_d;

  logic in_access, in_resp;
  logic if_elig, mem_elig, arb, grant_mem;

  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  // The current owner's request is still high during RESP and must not re-win.
  assign if_elig   = if_req  && !(in_resp && owner_q == OWN_IF);
  assign mem_elig  = mem_req && !(in_resp && owner_q == OWN_MEM);
  assign arb       = (state_q == S_IDLE || in_resp) && (if_elig || mem_elig);
  assign grant_mem = mem_elig && (!if_elig || last_owner_q == OWN_IF);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    if_hold_d    = if_hold_q;
    mem_hold_d   = mem_hold_q;

    case (state_q)
      S_IDLE:   state_d = arb ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = arb ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (arb) begin
      owner_d      = grant_mem;
      last_owner_d = grant_mem;
      addr_d       = grant_mem ? mem_addr : if_addr;
      wdata_d      = grant_mem ? mem_wdata : 32'h0;
      we_d         = grant_mem && mem_we;
    end

    // Read data arrives in RESP; capture it for the owner (uses the finishing access's we).
    if (in_resp && !we_q) begin
      if (owner_q == OWN_MEM) mem_hold_d = mmu_input_data;
      else                    if_hold_d  = mmu_input_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      if_hold_q    <= 32'h0;
      mem_hold_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      if_hold_q    <= if_hold_d;
      mem_hold_q   <= mem_hold_d;
    end
  end

  assign mmu_address     = in_access ? addr_q  : 32'h0;
  assign mmu_output_data = in_access ? wdata_q : 32'h0;
  assign mmu_we          = in_access && we_q;

  assign if_ack    = in_resp && (owner_q == OWN_IF);
  assign mem_ack   = in_resp && (owner_q == OWN_MEM);
  assign if_rdata  = (if_ack  && !we_q) ? mmu_input_data : if_hold_q;
  assign mem_rdata = (mem_ack && !we_q) ? mmu_input_data : mem_hold_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Directed bench for cpu_memory_arbiter with a one-cycle synchronous memory model.
module tb_cpu_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_ack, mem_ack;
  logic [31:0] mmu_address, mmu_output_data, mmu_input_data;
  logic        mmu_we, o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_arr [0:255];

  always #5 clk = ~clk;

  cpu_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mmu_address(mmu_address), .mmu_output_data(mmu_output_data), .mmu_we(mmu_we),
    .mmu_input_data(mmu_input_data), .o_busy(o_busy)
  );

  // Memory: write and read both act on the rising edge; read data valid next cycle.
  always @(posedge clk) begin
    if (mmu_we) mem_arr[mmu_address[9:2]] <= mmu_output_data;
    mmu_input_data <= mem_arr[mmu_address[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests_run++;
    if ({o_busy, if_ack, mem_ack, mmu_we} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got busy/ifack/memack/we=%b required 0000", {o_busy, if_ack, mem_ack, mmu_we});
    end
    tests_run++;
    if ({if_rdata, mem_rdata, mmu_address, mmu_output_data} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_data got %h %h %h %h required all 0", if_rdata, mem_rdata, mmu_address, mmu_output_data);
    end
    tick();
    reset = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_single_load();
    mem_req = 1'b1; mem_addr = 32'h100; mem_we = 1'b0;
    tick();
    tests_run++;
    if (mmu_address !== 32'h100 || mmu_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_access got addr=%h we=%b required 00000100 0", mmu_address, mmu_we);
    end
    tick();
    tests_run++;
    if (mem_ack !== 1'b1 || if_ack !== 1'b0 || mem_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL load_resp got ack=%b ifack=%b rdata=%h required 1 0 deadbeef", mem_ack, if_ack, mem_rdata);
    end
    tick();
    mem_req = 1'b0;
    tick();
    tests_run++;
    if (mem_rdata !== 32'hDEADBEEF || mem_ack !== 1'b0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_hold got rdata=%h ack=%b busy=%b required deadbeef 0 0", mem_rdata, mem_ack, o_busy);
    end
    $display("[TB] load 0x100 -> %h", mem_rdata);
  endtask

  task automatic test_single_store();
    mem_req = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_we = 1'b1;
    tick();
    tests_run++;
    if (mmu_we !== 1'b1 || mmu_address !== 32'h20 || mmu_output_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL store_access got we=%b addr=%h data=%h required 1 00000020 12345678", mmu_we, mmu_address, mmu_output_data);
    end
    tick();
    tests_run++;
    if (mmu_we !== 1'b0 || mem_ack !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL store_resp got we=%b ack=%b rdata=%h required 0 1 deadbeef", mmu_we, mem_ack, mem_rdata);
    end
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    tests_run++;
    if (mem_arr[8] !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL store_commit got %h required 12345678", mem_arr[8]);
    end
    // Read the stored word back through the arbiter.
    tick();
    mem_req = 1'b1; mem_addr = 32'h20;
    tick();
    tick();
    tests_run++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL store_readback got ack=%b rdata=%h required 1 12345678", mem_ack, mem_rdata);
    end
    tick();
    mem_req = 1'b0;
    tick();
    $display("[TB] store 0x20 <- 12345678");
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_addr = 32'h0; mem_addr = 32'h40; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    tick();
    tests_run++;
    if (mmu_address !== 32'h40) begin
      tests_failed++;
      $display("FAIL simul_first_addr got %h required 00000040", mmu_address);
    end
    tick();
    tests_run++;
    if (mem_ack !== 1'b1 || if_ack !== 1'b0 || mem_rdata !== 32'h5555AAAA) begin
      tests_failed++;
      $display("FAIL simul_mem_ack got memack=%b ifack=%b rdata=%h required 1 0 5555aaaa", mem_ack, if_ack, mem_rdata);
    end
    tick();
    mem_req = 1'b0;
    tests_run++;
    if (mmu_address !== 32'h0 || o_busy !== 1'b1 || mem_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_if_access got addr=%h busy=%b memack=%b required 0 1 0", mmu_address, o_busy, mem_ack);
    end
    tick();
    tests_run++;
    if (if_ack !== 1'b1 || mem_ack !== 1'b0 || if_rdata !== 32'hA0A00000) begin
      tests_failed++;
      $display("FAIL simul_if_ack got ifack=%b memack=%b rdata=%h required 1 0 a0a00000", if_ack, mem_ack, if_rdata);
    end
    tick();
    if_req = 1'b0;
    tick();
    $display("[TB] simultaneous: mem then if");
  endtask

  task automatic test_fairness();
    logic expect_mem;
    int   grants;
    do_reset();
    if_addr = 32'h0; mem_addr = 32'h40; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    expect_mem = 1'b1;
    grants = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      tick();
      if (if_ack || mem_ack) begin
        tests_run++;
        if (if_ack === mem_ack || mem_ack !== expect_mem) begin
          tests_failed++;
          $display("FAIL fair_grant%0d got memack=%b ifack=%b required memack=%b", grants, mem_ack, if_ack, expect_mem);
        end
        $display("[TB] grant %0d -> %s", grants, mem_ack ? "MEM" : "IF");
        expect_mem = ~expect_mem;
        grants++;
      end
    end
    tests_run++;
    if (grants != 10) begin
      tests_failed++;
      $display("FAIL fair_count got %0d grants required 10", grants);
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int exp_ack;
    if_addr = 32'h0;
    if_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_ack = (c == 2 || c == 5 || c == 8) ? 1 : 0;
      tests_run++;
      if (if_ack !== exp_ack[0] || (exp_ack == 1 && if_rdata !== 32'hA0A00000)) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d got ack=%b rdata=%h required ack=%0d", c, if_ack, if_rdata, exp_ack);
      end
      if (c == 3 || c == 6) begin
        tests_run++;
        if (o_busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_idle%0d got busy=%b required 0", c, o_busy);
        end
      end
    end
    tick();
    if_req = 1'b0;
    tick();
    $display("[TB] back-to-back fetch x3");
  endtask

  task automatic test_reset_midaccess();
    mem_req = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hCAFEF00D; mem_we = 1'b1;
    tick();
    tests_run++;
    if (mmu_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre got mmu_we=%b required 1", mmu_we);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({mmu_we, mem_ack, if_ack, o_busy} !== 4'b0) begin
      tests_failed++;
      $display("FAIL rst_async got we/memack/ifack/busy=%b required 0000", {mmu_we, mem_ack, if_ack, o_busy});
    end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (o_busy !== 1'b0 || mem_ack !== 1'b0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_after got busy=%b ack=%b ifr=%h memr=%h required 0 0 0 0", o_busy, mem_ack, if_rdata, mem_rdata);
    end
    $display("[TB] reset during store access");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
    mem_arr[0]  <= 32'hA0A00000;
    mem_arr[16] <= 32'h5555AAAA;
    mem_arr[64] <= 32'hDEADBEEF;
    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0;
    #1;
    test_reset();
    test_single_load();
    test_single_store();
    test_simultaneous();
    test_fairness();
    test_back_to_back();
    test_reset_midaccess();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
